// File: rtl/lz77_pkg.sv
// Shared types and constants for the LZ77 encoder arbiter slice.
// Contents: FSM state enum, codeword payload struct, terminator char, field widths.
package lz77_pkg;

    localparam int unsigned OFF_W  = 4;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned CHAR_W = 8;

    localparam logic [CHAR_W-1:0] LZ77_TERM_CHAR = 8'h24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERST  = 3'd1,
        ST_FEED  = 3'd2,
        ST_TERM  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } lz77_state_e;

    // Output FIFO entry, MSB first: {src, last, offset, match_len, char_nxt}
    typedef struct packed {
        logic              src;
        logic              last;
        logic [OFF_W-1:0]  offset;
        logic [LEN_W-1:0]  match_len;
        logic [CHAR_W-1:0] char_nxt;
    } lz77_cw_t;

    localparam int unsigned CW_W = 2 + OFF_W + LEN_W + CHAR_W;

endpackage

// File: rtl/lz77_enc_arbiter_if.sv
// Bundle of the arbiter's source, encoder and codeword-sink signals.
// master: the arbiter (drives src_ready, enc_reset, enc_chardata, cw_valid,
//         cw_data, busy, err_gap, err_ovf).
// slave:  the surrounding environment (loaders, encoder, sink).
interface lz77_enc_arbiter_if;
    import lz77_pkg::*;

    logic [1:0]        src_valid;
    logic [CHAR_W-1:0] src_data0;
    logic [CHAR_W-1:0] src_data1;
    logic [1:0]        src_ready;

    logic              enc_reset;
    logic [CHAR_W-1:0] enc_chardata;
    logic              enc_valid;
    logic              enc_encode;
    logic              enc_finish;
    logic [OFF_W-1:0]  enc_offset;
    logic [LEN_W-1:0]  enc_match_len;
    logic [CHAR_W-1:0] enc_char_nxt;

    logic              cw_valid;
    logic              cw_ready;
    logic [CW_W-1:0]   cw_data;

    logic              busy;
    logic              err_gap;
    logic              err_ovf;

    modport master (
        input  src_valid, src_data0, src_data1,
        output src_ready,
        output enc_reset, enc_chardata,
        input  enc_valid, enc_encode, enc_finish, enc_offset, enc_match_len, enc_char_nxt,
        output cw_valid, cw_data,
        input  cw_ready,
        output busy, err_gap, err_ovf
    );

    modport slave (
        output src_valid, src_data0, src_data1,
        input  src_ready,
        input  enc_reset, enc_chardata,
        output enc_valid, enc_encode, enc_finish, enc_offset, enc_match_len, enc_char_nxt,
        input  cw_valid, cw_data,
        output cw_ready,
        input  busy, err_gap, err_ovf
    );

endinterface

// File: rtl/lz77_cw_fifo.sv
// Synchronous codeword FIFO with full/empty flags and simultaneous push/pop.
// Ports: clk, reset (sync, active-high), i_push/i_data, i_pop,
//        o_data (zero while empty), o_full, o_empty.
// A push while full is accepted only if a pop happens in the same cycle.
module lz77_cw_fifo
    import lz77_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     i_push,
    input  lz77_cw_t i_data,
    input  logic     i_pop,
    output lz77_cw_t o_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    lz77_cw_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd];

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + PTR_W'(1);
            if (w_do_pop)  r_rd <= r_rd + PTR_W'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/lz77_enc_arbiter.sv
// Round-robin scheduler sharing one LZ77 encoder between two image sources.
// Streams IMG_LEN characters of the granted source, appends '$', resets the
// encoder between images and collects codewords into a source-tagged FIFO.
// Ports: clk, reset (sync, active-high), bus (lz77_enc_arbiter_if.master):
//   src_valid/src_data0/src_data1/src_ready, enc_reset/enc_chardata,
//   enc_valid/enc_encode/enc_finish/enc_offset/enc_match_len/enc_char_nxt,
//   cw_valid/cw_ready/cw_data, busy, err_gap, err_ovf.
// Optional: LZ77_ENC_ARB_WDOG_EN adds a DRAIN watchdog (WDOG_CYCLES).
module lz77_enc_arbiter
    import lz77_pkg::*;
#(
    parameter int unsigned IMG_LEN     = 2048,
    parameter int unsigned FIFO_DEPTH  = 4
`ifdef LZ77_ENC_ARB_WDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES = 8192
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    lz77_enc_arbiter_if.master     bus
);

    localparam int unsigned CNT_W = 11;

    lz77_state_e       r_state, w_state_nxt;
    logic              r_grant, w_grant_nxt;
    logic              r_rr_ptr, w_rr_ptr_nxt;
    logic              r_erst_cnt, w_erst_cnt_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [1:0]        r_src_ready, w_src_ready_nxt;
    logic              r_enc_reset, w_enc_reset_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_err_gap, w_err_gap_nxt;
    logic              r_err_ovf, w_err_ovf_nxt;

    logic              w_gap;
    logic              w_cw_fire;
    logic              w_src_valid_g;
    logic [CHAR_W-1:0] w_src_data_g;
    logic [CHAR_W-1:0] w_chardata;
    logic              w_push;
    lz77_cw_t          w_push_data;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    lz77_cw_t          w_fifo_out;

`ifdef LZ77_ENC_ARB_WDOG_EN
    localparam int unsigned WDOG_W = 14;
    logic [WDOG_W-1:0] r_wdog, w_wdog_nxt;
`endif

    assign w_src_valid_g = bus.src_valid[r_grant];
    assign w_src_data_g  = r_grant ? bus.src_data1 : bus.src_data0;
    assign w_cw_fire     = bus.enc_valid && bus.enc_encode;
    assign w_pop         = !w_empty && bus.cw_ready;

    // Next-state and output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_erst_cnt_nxt = r_erst_cnt;
        w_cnt_nxt      = r_cnt;
        w_err_gap_nxt  = r_err_gap;
        w_gap          = 1'b0;
        w_push         = 1'b0;
        w_push_data    = '0;
        w_chardata     = '0;
`ifdef LZ77_ENC_ARB_WDOG_EN
        w_wdog_nxt     = r_wdog;
`endif

        case (r_state)
            ST_IDLE: begin
                if (bus.src_valid != 2'b00) begin
                    // r_rr_ptr names the source that wins a tie
                    if (bus.src_valid == 2'b11) w_grant_nxt = r_rr_ptr;
                    else                        w_grant_nxt = bus.src_valid[1];
                    w_erst_cnt_nxt = 1'b0;
                    w_state_nxt    = ST_ERST;
                end
            end
            ST_ERST: begin
                if (r_erst_cnt) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_FEED;
                end else begin
                    w_erst_cnt_nxt = 1'b1;
                end
            end
            ST_FEED: begin
                // Combinational pass-through: the encoder sees the character in
                // the same cycle the source sees src_ready.
                w_chardata = w_src_data_g;
                if (!w_src_valid_g) begin
                    // Encoder cannot stall: abandon the image
                    w_gap         = 1'b1;
                    w_err_gap_nxt = 1'b1;
                    w_state_nxt   = ST_DONE;
                end else if (r_cnt == CNT_W'(IMG_LEN - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_TERM;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_TERM: begin
                w_chardata  = LZ77_TERM_CHAR;
                w_state_nxt = ST_DRAIN;
`ifdef LZ77_ENC_ARB_WDOG_EN
                w_wdog_nxt  = '0;
`endif
            end
            ST_DRAIN: begin
                w_chardata = LZ77_TERM_CHAR;
                if (w_cw_fire) begin
                    w_push                = 1'b1;
                    w_push_data.src       = r_grant;
                    w_push_data.last      = bus.enc_finish;
                    w_push_data.offset    = bus.enc_offset;
                    w_push_data.match_len = bus.enc_match_len;
                    w_push_data.char_nxt  = bus.enc_char_nxt;
                    if (bus.enc_finish) w_state_nxt = ST_DONE;
                end
`ifdef LZ77_ENC_ARB_WDOG_EN
                w_wdog_nxt = r_wdog + WDOG_W'(1);
                // Encoder never finished: close the image with an empty last entry
                if (!(w_cw_fire && bus.enc_finish) && (r_wdog == WDOG_W'(WDOG_CYCLES - 1))) begin
                    w_push           = 1'b1;
                    w_push_data      = '0;
                    w_push_data.src  = r_grant;
                    w_push_data.last = 1'b1;
                    w_err_gap_nxt    = 1'b1;
                    w_state_nxt      = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                // Equals a toggle after a tie; also hands priority away after an
                // uncontested grant.
                w_rr_ptr_nxt = ~r_grant;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt      = (w_state_nxt != ST_IDLE);
        w_enc_reset_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ERST) || w_gap;
        w_src_ready_nxt = (w_state_nxt == ST_FEED) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
        w_err_ovf_nxt   = r_err_ovf || (w_push && w_full && !w_pop);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= 1'b0;
            r_rr_ptr    <= 1'b0;
            r_erst_cnt  <= 1'b0;
            r_cnt       <= '0;
            r_src_ready <= 2'b00;
            r_enc_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_err_gap   <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_erst_cnt  <= w_erst_cnt_nxt;
            r_cnt       <= w_cnt_nxt;
            r_src_ready <= w_src_ready_nxt;
            r_enc_reset <= w_enc_reset_nxt;
            r_busy      <= w_busy_nxt;
            r_err_gap   <= w_err_gap_nxt;
            r_err_ovf   <= w_err_ovf_nxt;
        end
    end

`ifdef LZ77_ENC_ARB_WDOG_EN
    // DRAIN watchdog counter
    always_ff @(posedge clk) begin
        if (reset) r_wdog <= '0;
        else       r_wdog <= w_wdog_nxt;
    end
`endif

    lz77_cw_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.src_ready    = r_src_ready;
    assign bus.enc_reset    = r_enc_reset;
    assign bus.enc_chardata = w_chardata;
    assign bus.cw_valid     = !w_empty;
    assign bus.cw_data      = w_fifo_out;
    assign bus.busy         = r_busy;
    assign bus.err_gap      = r_err_gap;
    assign bus.err_ovf      = r_err_ovf;

endmodule

// File: tb/tb_lz77_enc_arbiter.sv
// Scoreboard bench for lz77_enc_arbiter: directed images, stub encoder driven
// from the stimulus process, codeword monitor popping an expected-entry queue.
// Define LZ77_ENC_ARB_WDOG_EN to also exercise the watchdog (WDOG_CYCLES = 16).
module tb_lz77_enc_arbiter;
    import lz77_pkg::*;

    localparam int unsigned IMG_LEN    = 2048;
    localparam int unsigned FIFO_DEPTH = 4;
`ifdef LZ77_ENC_ARB_WDOG_EN
    localparam int unsigned WDOG_CYCLES = 16;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lz77_enc_arbiter_if bus_if ();

    lz77_enc_arbiter #(
        .IMG_LEN     (IMG_LEN),
        .FIFO_DEPTH  (FIFO_DEPTH)
`ifdef LZ77_ENC_ARB_WDOG_EN
        ,
        .WDOG_CYCLES (WDOG_CYCLES)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.master)
    );

    int checks = 0;
    int errors = 0;
    lz77_cw_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] ch(input bit s, input int i);
        return 8'((i * 5) + (s ? 101 : 0) + 1);
    endfunction

    // Hand-picked codewords, including the offset/length extremes
    function automatic lz77_cw_t tab(input int k);
        lz77_cw_t e;
        e = '0;
        case (k)
            0:       begin e.offset = 4'd0; e.match_len = 3'd0; e.char_nxt = 8'h61; end
            1:       begin e.offset = 4'd8; e.match_len = 3'd7; e.char_nxt = 8'h62; end
            2:       begin e.offset = 4'd3; e.match_len = 3'd2; e.char_nxt = 8'h63; end
            3:       begin e.offset = 4'd1; e.match_len = 3'd1; e.char_nxt = 8'hff; end
            default: begin e.offset = 4'd8; e.match_len = 3'd0; e.char_nxt = 8'h00; end
        endcase
        return e;
    endfunction

    // Monitor: compare every popped codeword with the scoreboard head
    always begin
        @(negedge clk);
        #1;
        if (bus_if.cw_valid && bus_if.cw_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cw_unexpected actual=%0h required=no entry", bus_if.cw_data);
            end else begin
                chk("cw_data", 32'(bus_if.cw_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_src_ready"},    32'(bus_if.src_ready),    0);
        chk({tag, "_enc_reset"},    32'(bus_if.enc_reset),    1);
        chk({tag, "_enc_chardata"}, 32'(bus_if.enc_chardata), 0);
        chk({tag, "_cw_valid"},     32'(bus_if.cw_valid),     0);
        chk({tag, "_cw_data"},      32'(bus_if.cw_data),      0);
        chk({tag, "_busy"},         32'(bus_if.busy),         0);
        chk({tag, "_err_gap"},      32'(bus_if.err_gap),      0);
        chk({tag, "_err_ovf"},      32'(bus_if.err_ovf),      0);
    endtask

    // Grant, ERST and FEED of one image; stops at the TERM cycle or after a gap
    task automatic feed_image(input logic [1:0] v, input bit s, input int gap_at);
        int bad;
        logic [1:0] exp_rdy;
        bad = 0;
        exp_rdy = s ? 2'b10 : 2'b01;
        @(negedge clk);
        chk("pre_busy", 32'(bus_if.busy), 0);
        bus_if.src_data0 = ch(1'b0, 0);
        bus_if.src_data1 = ch(1'b1, 0);
        bus_if.src_valid = v;
        repeat (2) begin
            @(negedge clk);
            if (bus_if.src_ready !== 2'b00 || bus_if.enc_reset !== 1'b1 || bus_if.busy !== 1'b1) bad++;
        end
        chk("erst_phase", 32'(bad), 0);
        bad = 0;
        for (int i = 0; i < IMG_LEN; i++) begin
            @(negedge clk);
            if (i == gap_at) begin
                bus_if.src_valid[s] = 1'b0;
                @(negedge clk);
                chk("gap_enc_reset", 32'(bus_if.enc_reset), 1);
                chk("gap_err",       32'(bus_if.err_gap),   1);
                chk("gap_cw_valid",  32'(bus_if.cw_valid),  0);
                @(negedge clk);
                chk("gap_busy_fall", 32'(bus_if.busy),      0);
                chk("gap_feed",      32'(bad),              0);
                bus_if.src_valid = 2'b00;
                return;
            end
            if (bus_if.src_ready !== exp_rdy || bus_if.enc_chardata !== ch(s, i) || bus_if.enc_reset !== 1'b0)
                bad++;
            if (s) bus_if.src_data1 = ch(1'b1, i + 1);
            else   bus_if.src_data0 = ch(1'b0, i + 1);
        end
        chk("feed_stream", 32'(bad), 0);
        @(negedge clk);
        chk("term_char",  32'(bus_if.enc_chardata), 32'h24);
        chk("term_ready", 32'(bus_if.src_ready),    0);
        bus_if.src_valid = 2'b00;
    endtask

    // Stub encoder: emits tab(first..first+n-1); first nret are expected out
    task automatic drain(input int first, input int n, input bit fin, input bit s, input int nret);
        lz77_cw_t e;
        @(negedge clk);
        bus_if.enc_valid  = 1'b1;
        bus_if.enc_encode = 1'b0;
        bus_if.enc_finish = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            e      = tab(first + k);
            e.src  = s;
            e.last = fin && (k == n - 1);
            bus_if.enc_valid     = 1'b1;
            bus_if.enc_encode    = 1'b1;
            bus_if.enc_finish    = e.last;
            bus_if.enc_offset    = e.offset;
            bus_if.enc_match_len = e.match_len;
            bus_if.enc_char_nxt  = e.char_nxt;
            if (k < nret) exp_q.push_back(e);
        end
        @(negedge clk);
        bus_if.enc_valid  = 1'b0;
        bus_if.enc_encode = 1'b0;
        bus_if.enc_finish = 1'b0;
        if (fin) begin
            chk("done_busy", 32'(bus_if.busy), 1);
            @(negedge clk);
            chk("idle_busy",      32'(bus_if.busy),      0);
            chk("idle_enc_reset", 32'(bus_if.enc_reset), 1);
        end
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        chk({name, "_pending"}, 32'(exp_q.size()),     0);
        chk({name, "_valid"},   32'(bus_if.cw_valid), 0);
    endtask

    initial begin
        reset                = 1'b1;
        bus_if.src_valid     = 2'b00;
        bus_if.src_data0     = '0;
        bus_if.src_data1     = '0;
        bus_if.enc_valid     = 1'b0;
        bus_if.enc_encode    = 1'b0;
        bus_if.enc_finish    = 1'b0;
        bus_if.enc_offset    = '0;
        bus_if.enc_match_len = '0;
        bus_if.enc_char_nxt  = '0;
        bus_if.cw_ready      = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;

        // Tie after reset: source 0 first, three codewords, last on the third
        feed_image(2'b11, 1'b0, -1);
        drain(0, 3, 1'b1, 1'b0, 3);
        wait_empty("img_a");

        // Tie again: source 1 now wins
        feed_image(2'b11, 1'b1, -1);
        drain(3, 2, 1'b1, 1'b1, 2);
        wait_empty("img_b");

        // Gap at character 100 on source 0
        feed_image(2'b01, 1'b0, 100);
        wait_empty("img_gap");

        // Overflow: sink stalled, five codewords into a 4-deep FIFO
        chk("ovf_before", 32'(bus_if.err_ovf), 0);
        bus_if.cw_ready = 1'b0;
        feed_image(2'b10, 1'b1, -1);
        drain(0, 5, 1'b1, 1'b1, 4);
        chk("ovf_flag",  32'(bus_if.err_ovf),  1);
        chk("ovf_valid", 32'(bus_if.cw_valid), 1);
        bus_if.cw_ready = 1'b1;
        wait_empty("img_ovf");

        // Reset in DRAIN with two entries held in the FIFO
        bus_if.cw_ready = 1'b0;
        feed_image(2'b01, 1'b0, -1);
        drain(1, 2, 1'b0, 1'b0, 2);
        chk("mid_busy",  32'(bus_if.busy),     1);
        chk("mid_valid", 32'(bus_if.cw_valid), 1);
        chk("mid_gap",   32'(bus_if.err_gap),  1);
        chk("mid_ovf",   32'(bus_if.err_ovf),  1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        exp_q.delete();
        reset = 1'b0;
        bus_if.cw_ready = 1'b1;
        wait_empty("post_rst");

`ifdef LZ77_ENC_ARB_WDOG_EN
        // Watchdog: encoder never finishes
        begin
            lz77_cw_t e;
            int bad;
            bad = 0;
            feed_image(2'b01, 1'b0, -1);
            e = '0;
            e.src = 1'b0;
            e.last = 1'b1;
            exp_q.push_back(e);
            repeat (WDOG_CYCLES) begin
                @(negedge clk);
                if (bus_if.cw_valid !== 1'b0) bad++;
            end
            chk("wdog_early", 32'(bad), 0);
            @(negedge clk);
            chk("wdog_valid", 32'(bus_if.cw_valid), 1);
            chk("wdog_gap",   32'(bus_if.err_gap),  1);
            wait_empty("wdog");
            chk("wdog_idle",  32'(bus_if.busy),     0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lz77_enc_arbiter.md
# lz77_enc_arbiter

Round-robin scheduler that shares one `LZ77_Encoder` instance between two image sources. It grants one source at a time and streams that source's characters into the encoder, then appends the `$` terminator. It drives the encoder's reset between images and captures every codeword into a source-tagged output FIFO with valid/ready handshake. It sits between the image loaders and the encoder/codeword sink.

## Interface
- `IMG_LEN`, 2048: characters per image, excluding the terminator.
- `FIFO_DEPTH`, 4: codeword FIFO entries; power of two, at least 2.
- `WDOG_CYCLES`, 8192: watchdog limit in DRAIN; used only with the watchdog macro.
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `src_valid[1:0]`  in  2: per-source character valid.
- `src_data0`, `src_data1`  in  8 each: per-source character.
- `src_ready[1:0]`  out  2: per-source character accept.
- `enc_reset`  out  1: reset to the encoder.
- `enc_chardata`  out  8: character to the encoder.
- `enc_valid`, `enc_encode`, `enc_finish`  in  1 each: encoder status.
- `enc_offset`  in  4: encoder codeword offset.
- `enc_match_len`  in  3: encoder codeword match length.
- `enc_char_nxt`  in  8: encoder codeword next character.
- `cw_valid`  out  1: output codeword valid.
- `cw_ready`  in  1: output codeword accept.
- `cw_data`  out  17: {src[16], last[15], offset[14:11], match_len[10:8], char_nxt[7:0]}.
- `busy`  out  1: an image is in progress.
- `err_gap`, `err_ovf`  out  1 each: sticky error flags; cleared only by `reset`.

## Operation
- **States:** IDLE, ERST, FEED, TERM, DRAIN, DONE.
- **IDLE:**
  - Wait for any `src_valid`.
  - Grant by round robin: the source not granted last wins ties.
  - After `reset`, source 0 has priority.
  - Latch the grant, then go to ERST.
- **ERST:** assert `enc_reset` for exactly 2 cycles, then go to FEED.
- **FEED:**
  - `src_ready[grant]` = 1 and `enc_chardata` = granted `src_data`.
  - The 11-bit character counter increments on each accepted character.
  - After `IMG_LEN` accepts, go to TERM.
  - `src_valid[grant]` low in FEED is a gap, because the encoder cannot stall. On a gap: set `err_gap`, drive `enc_reset` 1 cycle, and go to DONE with no `last` entry written.
- **TERM:** drive `enc_chardata` = 8'h24 and go to DRAIN.
- **DRAIN:**
  - `enc_chardata` holds 8'h24.
  - Each cycle with `enc_valid && enc_encode` pushes one entry into the FIFO.
  - If `enc_finish` is high in the same cycle, the pushed entry has `last` = 1 and the state moves to DONE.
  - Codewords carry `match_len` 0..7 and `offset` 0..8 unmodified.
  - A push into a full FIFO is dropped and sets `err_ovf`; the FSM continues.
- **DONE:** toggle the round-robin pointer and return to IDLE.
- **Outputs:** `busy` = 1 in every state except IDLE. The non-granted source always sees `src_ready` = 0.
- **FIFO:** a pop happens when `cw_valid && cw_ready`. A simultaneous push and pop on a full FIFO succeeds; it is not an overflow.

## Timing
- **Reset values:**
  - `src_ready` = 0, `enc_reset` = 1, `enc_chardata` = 0, `cw_valid` = 0, `cw_data` = 0, `busy` = 0, `err_*` = 0.
  - FIFO is empty, pointer points to source 0, state is IDLE.
- **Encoder reset:** `enc_reset` stays high throughout IDLE and drops on the first FEED cycle.
- **Startup:** the first character reaches the encoder exactly 3 cycles after the grant cycle.
- **FEED throughput:** one character per cycle, no bubbles; FEED lasts exactly `IMG_LEN` cycles.
- **Codeword latency:** capture to `cw_valid` is 1 cycle (registered FIFO output).
- **`reset` mid-image:** abandons the image, empties the FIFO, and clears all state the next cycle.

## Configuration
- `LZ77_ENC_ARB_WDOG_EN` defined:
  - A 14-bit counter runs in DRAIN.
  - If it reaches `WDOG_CYCLES` without `enc_finish`, the block writes one entry with `last` = 1 and codeword fields 0, sets `err_gap`, and goes to DONE.
- Not defined: no counter; DRAIN waits indefinitely.

## Structure
- Package `lz77_pkg`:
  - state enum;
  - codeword struct `{src, last, offset, match_len, char_nxt}`;
  - `LZ77_TERM_CHAR` = 8'h24;
  - widths `OFF_W` = 4, `LEN_W` = 3.
- Sub-module `lz77_cw_fifo`: synchronous FIFO with full/empty flags and simultaneous push/pop. All other logic is flat.

## Test plan
- Source 0 only, 2048 characters, stub encoder emitting 3 codewords with `finish` on the 3rd -> 3 FIFO entries with src = 0; `last` = 1 only on the 3rd; the 2049th `enc_chardata` is 8'h24.
- Both sources valid in the same cycle after `reset` -> source 0 granted first; source 1 granted at the next IDLE.
- `src_valid[grant]` dropped at character 100 -> `err_gap` = 1, `enc_reset` pulses, `busy` falls within 2 cycles.
- `cw_ready` = 0 with 5 codewords emitted and `FIFO_DEPTH` = 4 -> 4 entries retained, `err_ovf` = 1.
- `reset` asserted during DRAIN -> all outputs at reset values next cycle, `cw_valid` = 0.
- `LZ77_ENC_ARB_WDOG_EN` with `WDOG_CYCLES` = 16 and `finish` never asserted -> `last` entry with zero codeword fields after 16 DRAIN cycles.
